// File: rtl/bus_matrix_pkg.sv
// Shared types and index helpers for the bus_matrix interconnect.
package bus_matrix_pkg;

    typedef enum logic [1:0] {
        DRIVEN,
        HOLDING,
        PRECHARGED
    } charge_state_t;

    function automatic int unsigned src_lsb(input int unsigned s, input int unsigned data_w);
        return s * data_w;
    endfunction

    function automatic int unsigned bus_lsb(input int unsigned b, input int unsigned data_w);
        return b * data_w;
    endfunction

    function automatic int unsigned drive_idx(input int unsigned b, input int unsigned s,
                                              input int unsigned num_src);
        return b * num_src + s;
    endfunction

    // $clog2(1) is 0, so HOLD_CYCLES=0 still needs a one-bit counter.
    function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
        return (hold_cycles == 0) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/bus_matrix_lane.sv
// One bus: wired-AND resolution, pull-downs, charge retention FSM, contention detect.
// Contention logic is present only with BUS_MATRIX_CONTENTION_EN defined.
module bus_matrix_lane
    import bus_matrix_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        drive,
    input  logic [DATA_W-1:0]         pull_low,
    input  logic                      clear_err,
    output logic [DATA_W-1:0]         bus,
    output logic                      driven,
    output logic                      contention,
    output logic                      hit
);

    localparam int unsigned     CW       = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CW-1:0]   HOLD_MAX = CW'(HOLD_CYCLES);

    charge_state_t       state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [DATA_W-1:0]   bus_n, resolved, first;
    logic                any, conflict;

    // Contention means some driver disagrees with the first one found.
    always_comb begin
        resolved = '1;
        first    = '0;
        any      = 1'b0;
        conflict = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (drive[s]) begin
                if (any && (src_data[src_lsb(s, DATA_W) +: DATA_W] != first))
                    conflict = 1'b1;
                if (!any)
                    first = src_data[src_lsb(s, DATA_W) +: DATA_W];
                any      = 1'b1;
                resolved = resolved & src_data[src_lsb(s, DATA_W) +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bus_n   = bus;
        if (any) begin
            state_n = DRIVEN;
            cnt_n   = '0;
            bus_n   = resolved & ~pull_low;
        end else if (state != PRECHARGED && cnt != HOLD_MAX) begin
            cnt_n   = cnt + CW'(1);
            state_n = (cnt_n == HOLD_MAX) ? PRECHARGED : HOLDING;
            bus_n   = bus & ~pull_low;
        end else begin
            state_n = PRECHARGED;
            cnt_n   = HOLD_MAX;
            bus_n   = ~pull_low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= PRECHARGED;
            cnt    <= HOLD_MAX;
            bus    <= '1;
            driven <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bus    <= bus_n;
            driven <= any;
        end
    end

`ifdef BUS_MATRIX_CONTENTION_EN
    assign hit = conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            contention <= 1'b0;
        else if (conflict)
            contention <= 1'b1;
        else if (clear_err)
            contention <= 1'b0;
    end
`else
    logic unused_detect;
    assign unused_detect = conflict ^ clear_err;
    assign hit           = 1'b0;
    assign contention    = 1'b0;
`endif

endmodule

// File: rtl/bus_matrix.sv
// Registered NUM_SRC x NUM_BUS wired-AND bus interconnect with charge retention.
// Contention flags/counter are functional only with BUS_MATRIX_CONTENTION_EN defined.
module bus_matrix
    import bus_matrix_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned NUM_BUS     = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
    input  logic [NUM_SRC*NUM_BUS-1:0] i_drive,
    input  logic [NUM_BUS*DATA_W-1:0] i_pull_low,
    input  logic                      i_clear_err,
    output logic [NUM_BUS*DATA_W-1:0] o_bus,
    output logic [NUM_BUS-1:0]        o_driven,
    output logic [NUM_BUS-1:0]        o_contention,
    output logic [CNT_W-1:0]          o_contention_cnt
);

    logic [NUM_BUS-1:0] hit;

    for (genvar b = 0; b < NUM_BUS; b++) begin : g_lane
        bus_matrix_lane #(
            .DATA_W      (DATA_W),
            .NUM_SRC     (NUM_SRC),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_lane (
            .clk        (i_clk),
            .rst        (i_reset),
            .src_data   (i_src_data),
            .drive      (i_drive[drive_idx(b, 0, NUM_SRC) +: NUM_SRC]),
            .pull_low   (i_pull_low[bus_lsb(b, DATA_W) +: DATA_W]),
            .clear_err  (i_clear_err),
            .bus        (o_bus[bus_lsb(b, DATA_W) +: DATA_W]),
            .driven     (o_driven[b]),
            .contention (o_contention[b]),
            .hit        (hit[b])
        );
    end

`ifdef BUS_MATRIX_CONTENTION_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // A contention cycle overrides a simultaneous clear, restarting at 1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            cnt <= '0;
        else if (|hit)
            cnt <= i_clear_err ? CNT_ONE : ((cnt == CNT_MAX) ? cnt : cnt + CNT_ONE);
        else if (i_clear_err)
            cnt <= '0;
    end

    assign o_contention_cnt = cnt;
`else
    logic unused_ctl;
    assign unused_ctl       = (^hit) ^ i_clear_err;
    assign o_contention_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_matrix.sv
// Self-checking bench for bus_matrix: two instances (HOLD_CYCLES 2 and 0) versus a behavioural model.
module tb_bus_matrix;

    localparam int DW = 8;
    localparam int NS = 8;
    localparam int NB = 4;
    localparam int CW = 8;
`ifdef BUS_MATRIX_CONTENTION_EN
    localparam bit CON_EN = 1'b1;
`else
    localparam bit CON_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*DW-1:0]  src;
    logic [NS*NB-1:0]  drv;
    logic [NB*DW-1:0]  pl;
    logic              clr;

    logic [NB*DW-1:0]  bus_a, bus_z;
    logic [NB-1:0]     drv_a, drv_z, con_a, con_z;
    logic [CW-1:0]     cnt_a, cnt_z;

    bus_matrix #(.DATA_W(DW), .NUM_SRC(NS), .NUM_BUS(NB), .HOLD_CYCLES(2), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(rst), .i_src_data(src), .i_drive(drv), .i_pull_low(pl),
        .i_clear_err(clr), .o_bus(bus_a), .o_driven(drv_a), .o_contention(con_a),
        .o_contention_cnt(cnt_a)
    );

    bus_matrix #(.DATA_W(DW), .NUM_SRC(NS), .NUM_BUS(NB), .HOLD_CYCLES(0), .CNT_W(CW)) dut_h0 (
        .i_clk(clk), .i_reset(rst), .i_src_data(src), .i_drive(drv), .i_pull_low(pl),
        .i_clear_err(clr), .o_bus(bus_z), .o_driven(drv_z), .o_contention(con_z),
        .o_contention_cnt(cnt_z)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          hold_of [2] = '{2, 0};
    logic [7:0]  m_bus [2][NB];
    int          m_cnt [2][NB];
    logic [NB-1:0] m_drv;
    logic [NB-1:0] m_flag;
    int          m_ctr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < NB; b++) begin
                m_bus[k][b] = 8'hFF;
                m_cnt[k][b] = hold_of[k];
            end
        m_drv  = '0;
        m_flag = '0;
        m_ctr  = 0;
    endtask

    // Applies one clock of the bus rules to the current inputs.
    task automatic model_step();
        logic [NB-1:0] hitv;
        logic [7:0]    val, first, d, pull;
        int            n;
        bit            diff;
        hitv = '0;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < NB; b++) begin
                n = 0; val = 8'hFF; first = 8'h00; diff = 0;
                for (int s = 0; s < NS; s++) begin
                    if (drv[b*NS + s]) begin
                        d = src[s*DW +: DW];
                        if (n == 0) first = d;
                        else if (d != first) diff = 1;
                        val = val & d;
                        n++;
                    end
                end
                pull = pl[b*DW +: DW];
                if (n > 0) begin
                    m_bus[k][b] = val & ~pull;
                    m_cnt[k][b] = 0;
                end else if (m_cnt[k][b] < hold_of[k]) begin
                    m_bus[k][b] = m_bus[k][b] & ~pull;
                    m_cnt[k][b]++;
                end else begin
                    m_bus[k][b] = 8'hFF & ~pull;
                end
                if (k == 0) begin
                    m_drv[b] = (n > 0);
                    hitv[b]  = diff;
                end
            end
        end
        if (CON_EN) begin
            for (int b = 0; b < NB; b++)
                if (hitv[b]) m_flag[b] = 1'b1;
                else if (clr) m_flag[b] = 1'b0;
            if (|hitv) m_ctr = clr ? 1 : ((m_ctr < 255) ? m_ctr + 1 : 255);
            else if (clr) m_ctr = 0;
        end
    endtask

    task automatic check_all();
        logic [NB*DW-1:0] e0, e1;
        for (int b = 0; b < NB; b++) begin
            e0[b*DW +: DW] = m_bus[0][b];
            e1[b*DW +: DW] = m_bus[1][b];
        end
        check("bus_h2", bus_a, e0);
        check("bus_h0", bus_z, e1);
        check("driven_h2", drv_a, m_drv);
        check("driven_h0", drv_z, m_drv);
        check("flags_h2", con_a, m_flag);
        check("flags_h0", con_z, m_flag);
        check("cnt_h2", cnt_a, m_ctr);
        check("cnt_h0", cnt_z, m_ctr);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_src(input int s, input logic [7:0] v);
        src[s*DW +: DW] = v;
    endtask

    task automatic set_drv(input int b, input int s);
        drv[b*NS + s] = 1'b1;
    endtask

    initial begin
        logic [7:0] pool [4];
        pool = '{8'hF0, 8'h3C, 8'hF0, 8'hA5};
        rst = 1'b1; src = '0; drv = '0; pl = '0; clr = 1'b0;
        model_reset();
        #12;
        check("reset_bus", bus_a, {NB{8'hFF}});
        check("reset_driven", drv_a, 0);
        check("reset_flags", con_a, 0);
        check("reset_cnt", cnt_a, 0);
        rst = 1'b0;

        // single driver then retention
        set_src(2, 8'h5A); set_drv(1, 2);
        cycle();
        check("hold_d", bus_a[15:8], 8'h5A);
        check("hold0_d", bus_z[15:8], 8'h5A);
        drv = '0;
        cycle();
        check("hold_1", bus_a[15:8], 8'h5A);
        check("hold0_pre", bus_z[15:8], 8'hFF);
        cycle();
        check("hold_2", bus_a[15:8], 8'h5A);
        cycle();
        check("hold_pre", bus_a[15:8], 8'hFF);

        // differing and identical multiple drivers
        set_src(0, 8'hF0); set_src(3, 8'h3C); set_drv(0, 0); set_drv(0, 3);
        cycle();
        check("and_bus", bus_a[7:0], 8'h30);
        check("con_flag", con_a[0], CON_EN);
        check("con_cnt", cnt_a, CON_EN ? 1 : 0);
        set_src(3, 8'hF0);
        cycle();
        check("same_bus", bus_a[7:0], 8'hF0);
        check("same_cnt", cnt_a, CON_EN ? 1 : 0);

        // pull-downs while driven and undriven
        drv = '0; set_src(1, 8'hFF); set_drv(2, 1); pl[23:16] = 8'h07;
        cycle();
        check("pull_drv", bus_a[23:16], 8'hF8);
        drv = '0; pl[23:16] = 8'h80;
        cycle();
        check("pull_pre0", bus_z[23:16], 8'h7F);
        check("pull_hold", bus_a[23:16], 8'h78);

        // counter saturation, clear colliding with contention
        pl = '0; drv = '0; clr = 1'b1;
        cycle();
        clr = 1'b0;
        set_src(0, 8'hF0); set_src(3, 8'h3C);
        set_drv(0, 0); set_drv(0, 3); set_drv(3, 0); set_drv(3, 3);
        for (int i = 0; i < 300; i++) cycle();
        check("sat_cnt", cnt_a, CON_EN ? 255 : 0);
        clr = 1'b1;
        cycle();
        check("clr_cnt", cnt_a, CON_EN ? 1 : 0);
        check("clr_flags", con_a, CON_EN ? 4'b1001 : 4'b0000);
        clr = 1'b0;

        // asynchronous reset while bus 1 holds 0x12
        drv = '0; set_src(5, 8'h12); set_drv(1, 5);
        cycle();
        drv = '0;
        cycle();
        check("pre_rst_hold", bus_a[15:8], 8'h12);
        #2 rst = 1'b1;
        #1;
        check("async_bus", bus_a, {NB{8'hFF}});
        check("async_bus_h0", bus_z, {NB{8'hFF}});
        check("async_driven", drv_a, 0);
        check("async_flags", con_a, 0);
        check("async_cnt", cnt_a, 0);
        model_reset();
        #2 rst = 1'b0;
        set_drv(2, 5);
        cycle();
        check("post_rst", bus_a[23:16], 8'h12);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            for (int s = 0; s < NS; s++)
                set_src(s, ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)]
                                                       : 8'($urandom));
            for (int j = 0; j < NS*NB; j++) drv[j] = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < NB; b++)
                pl[b*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            clr = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_matrix.md
# bus_matrix

Parametrised, registered internal-bus interconnect for the CPU datapath: NUM_SRC register sources drive NUM_BUS shared buses through per-source/per-bus enables, with NMOS-style wired-AND resolution, per-bit open-drain pull-downs and modelled bus charge retention that decays to the precharged all-ones state. It replaces hand-routed, fixed-width bus muxing. It also adds contention detection, so microcode sequencers can be checked for illegal multi-driver cycles.

## Interface
- DATA_W, 8, bus width in bits
- NUM_SRC, 8, number of data sources
- NUM_BUS, 4, number of buses
- HOLD_CYCLES, 2, undriven cycles a bus retains its last value before precharging; 0 = precharge immediately
- CNT_W, 8, width of contention counter
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_src_data  in  NUM_SRC*DATA_W  source s at [s*DATA_W +: DATA_W]
- i_drive  in  NUM_SRC*NUM_BUS  bit b*NUM_SRC+s: source s drives bus b
- i_pull_low  in  NUM_BUS*DATA_W  bit b*DATA_W+k forces bus b bit k to 0
- i_clear_err  in  1  clears sticky contention flags and counter
- o_bus  out  NUM_BUS*DATA_W  registered bus values, bus b at [b*DATA_W +: DATA_W]
- o_driven  out  NUM_BUS  bus had ≥1 driver in the sampled cycle
- o_contention  out  NUM_BUS  sticky per-bus contention flag
- o_contention_cnt  out  CNT_W  saturating count of cycles with contention on any bus

## Operation
- Per bus b, per cycle: D = set of sources with drive bit set.
- Resolved value R: if |D|≥1, bitwise AND of all data in D; otherwise as below. Then R &= ~pull_low[b].
- Per-bus charge state machine:
  - DRIVEN: |D|≥1; next o_bus = R; hold count ← 0.
  - HOLDING: |D|=0 and hold count < HOLD_CYCLES; next o_bus = previous o_bus & ~pull_low; count++.
  - PRECHARGED: |D|=0 and count = HOLD_CYCLES; next o_bus = all ones & ~pull_low; count stays saturated.
- Transitions: any driver → DRIVEN; from DRIVEN/HOLDING an undriven cycle advances the count; reaching HOLD_CYCLES enters PRECHARGED; HOLD_CYCLES=0 goes DRIVEN→PRECHARGED directly.
- Pull-low applies in every state and does not alter the hold count. A held value already carries earlier pull-downs.
- Contention on bus b: |D|≥2 and at least two driving sources differ in any bit. Identical data from several drivers is not contention.
- o_contention[b] sets on contention and stays set until i_clear_err.
- o_contention_cnt increments by 1 per cycle with contention on ≥1 bus, not per bus. It saturates at 2^CNT_W−1.
- Source index has no priority; resolution is symmetric.

## Timing
- All outputs registered; latency 1 cycle from inputs to o_bus/o_driven/o_contention/o_contention_cnt.
- Reset values: o_bus all ones; o_driven 0; o_contention 0; o_contention_cnt 0; hold counts = HOLD_CYCLES (PRECHARGED).
- Reset asserted mid-operation forces reset values immediately (asynchronously). The first edge after deassert samples inputs normally.
- i_clear_err together with new contention in the same cycle: the flag ends set and the counter ends at 1 (set/increment wins over clear).
- Counter at saturation with i_clear_err and contention: the result is 1.

## Configuration
- BUS_MATRIX_CONTENTION_EN defined: contention detection, o_contention and o_contention_cnt are functional as above.
- Not defined: detection logic is omitted. o_contention is tied to 0 and o_contention_cnt to 0, ports remain, and i_clear_err is ignored. Bus resolution is unchanged.

## Structure
- Package bus_matrix_pkg holds:
  - charge-state enum (DRIVEN, HOLDING, PRECHARGED);
  - index helper functions for the flattened src/bus/drive vectors;
  - a localparam-style helper for hold-counter width $clog2(HOLD_CYCLES+1), minimum 1.
- Sub-module bus_matrix_lane: one per bus via generate. It owns resolution, pull-low, the charge FSM, its o_bus slice and its contention detect.
- The top level contains only lane instantiation, the any-bus contention OR and the shared saturating counter.

## Test plan
- Reset, no drivers → o_bus all 0xFF on every bus, o_driven 0, all flags 0.
- Source 2 = 0x5A drives bus 1 for 1 cycle, then undriven, HOLD_CYCLES=2 → bus 1 reads 0x5A for 3 cycles (driven + 2 hold), then 0xFF.
- Sources 0 = 0xF0 and 3 = 0x3C both drive bus 0 → bus 0 = 0x30, o_contention[0]=1, counter=1. Repeat with both 0xF0 → 0xF0, no new contention.
- Source 1 = 0xFF drives bus 2 with pull_low bits 0–2 → bus 2 = 0xF8. Undriven with pull_low bit 7 only and HOLD_CYCLES=0 → 0x7F.
- Contention on buses 0 and 3 in the same cycle for 300 cycles, CNT_W=8 → counter 255 (increments once per cycle, saturates). i_clear_err in a contention cycle → counter 1, flags remain set.
- Async reset pulse mid-hold (bus holding 0x12) → o_bus 0xFF immediately without a clock edge. Rebuild without BUS_MATRIX_CONTENTION_EN → contention outputs stay 0 under the third scenario's stimulus.
